// File: rtl/fifo_feed_ctrl.sv
// Start-up sequencer: waits, pulses the processor reset, then streams one frame from a sample ROM into a FIFO.
// Optional macro FEED_LOOP_EN: repeat the frame continuously until stop instead of stopping in DONE.
module fifo_feed_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 10,
  parameter int FRAME_LEN   = 640,
  parameter int STARTUP_CYC = 16383,
  parameter int RST_CYC     = 1,
  parameter int WR_GAP      = 2,
  parameter int USEDW_W     = 7,
  parameter int HIGH_WM     = 60
) (
  input  logic                     clk,
  input  logic                     rst_geral,
  input  logic                     start,
  input  logic                     stop,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic signed [DATA_W-1:0] rom_data,
  input  logic                     fifo_full,
  input  logic [USEDW_W-1:0]       fifo_usedw,
  output logic signed [DATA_W-1:0] fifo_data,
  output logic                     fifo_wrreq,
  output logic                     rst_proc,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_PRST, S_ADDR, S_DATA, S_GAP, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  state_t                    state_q, state_d;
  logic [31:0]               cnt_q, cnt_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic signed [DATA_W-1:0]  data_q, data_d;
  logic                      wrreq_q, wrreq_d;
  logic                      rst_proc_q, rst_proc_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [15:0]               frame_q, frame_d;
  logic                      stall;

  assign stall = fifo_full || (32'(fifo_usedw) >= 32'(HIGH_WM));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wrreq_d    = 1'b0;
    rst_proc_d = rst_proc_q;
    frame_d    = frame_q;
`ifdef FEED_LOOP_EN
    done_d     = 1'b0;
`else
    done_d     = done_q;
`endif
    if (stop) begin
      state_d    = S_IDLE;
      rst_proc_d = 1'b0;
      done_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_DELAY;
            cnt_d   = '0;
            addr_d  = '0;
            frame_d = '0;
            done_d  = 1'b0;
          end
        end
        S_DELAY: begin
          if (cnt_q == 32'(STARTUP_CYC - 1)) begin
            state_d    = S_PRST;
            cnt_d      = '0;
            rst_proc_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_PRST: begin
          if (cnt_q == 32'(RST_CYC - 1)) begin
            state_d    = S_ADDR;
            cnt_d      = '0;
            rst_proc_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_ADDR: state_d = S_DATA;
        // rom_data is valid here because rom_addr has been stable since ADDR
        S_DATA: begin
          if (!stall) begin
            data_d  = rom_data;
            wrreq_d = 1'b1;
            cnt_d   = '0;
            state_d = S_GAP;
          end
        end
        S_GAP: begin
          if (cnt_q == 32'(WR_GAP - 1)) begin
            cnt_d = '0;
            if (addr_q == LAST_IDX) begin
              frame_d = frame_q + 16'd1;
              done_d  = 1'b1;
`ifdef FEED_LOOP_EN
              addr_d  = '0;
              state_d = S_ADDR;
`else
              state_d = S_DONE;
`endif
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = S_ADDR;
            end
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = !(state_d == S_IDLE || state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst_geral) begin
    if (rst_geral) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wrreq_q    <= 1'b0;
      rst_proc_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      frame_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wrreq_q    <= wrreq_d;
      rst_proc_q <= rst_proc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      frame_q    <= frame_d;
    end
  end

  assign rom_addr   = addr_q;
  assign fifo_data  = data_q;
  assign fifo_wrreq = wrreq_q;
  assign rst_proc   = rst_proc_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign frame_cnt  = frame_q;

endmodule

// File: tb/tb_fifo_feed_ctrl.sv
// Bench for fifo_feed_ctrl: timing model derived from write-slot arithmetic, randomized FIFO back-pressure.
`timescale 1ns/1ps
module tb_fifo_feed_ctrl;
  localparam int DATA_W = 16, ADDR_W = 10, FRAME_LEN = 8, STARTUP_CYC = 5, RST_CYC = 2;
  localparam int WR_GAP = 2, USEDW_W = 7, HIGH_WM = 6;
  localparam int PERIOD = 2 + WR_GAP;
`ifdef FEED_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_geral, start, stop, fifo_full, fifo_wrreq, rst_proc, busy, done;
  logic [USEDW_W-1:0] fifo_usedw;
  logic [ADDR_W-1:0] rom_addr;
  logic signed [DATA_W-1:0] rom_data, fifo_data;
  logic [15:0] frame_cnt;
  int cyc = 0, errors = 0, checks = 0;

  fifo_feed_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_LEN(FRAME_LEN), .STARTUP_CYC(STARTUP_CYC),
                   .RST_CYC(RST_CYC), .WR_GAP(WR_GAP), .USEDW_W(USEDW_W), .HIGH_WM(HIGH_WM)) dut (
    .clk(clk), .rst_geral(rst_geral), .start(start), .stop(stop), .rom_addr(rom_addr),
    .rom_data(rom_data), .fifo_full(fifo_full), .fifo_usedw(fifo_usedw), .fifo_data(fifo_data),
    .fifo_wrreq(fifo_wrreq), .rst_proc(rst_proc), .busy(busy), .done(done), .frame_cnt(frame_cnt));

  always #5 clk = ~clk;

  function automatic logic signed [DATA_W-1:0] rom_val(input int a);
    int v;
    v = 100 * a - 300;
    return v[DATA_W-1:0];
  endfunction

  always @(posedge clk) rom_data <= rom_val(int'(rom_addr));

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Write k may issue at the first edge >= its slot whose preceding cycle shows no back-pressure.
  task automatic run_frame(input int mode, input int stop_after, output int n_frames, output int n_pulses);
    int s, wr_idx, earliest, done_edge, writes, hold, wm_cnt;
    bit stall_in, exp_wr, exp_done, exp_busy, exp_rp, bp_used, finished;
    logic signed [DATA_W-1:0] exp_data;
    n_frames = 0; n_pulses = 0; wr_idx = 0; writes = 0; hold = 0; wm_cnt = 0;
    bp_used = 0; finished = 0; done_edge = -1;
    fifo_full = 1'b0; fifo_usedw = '0; stop = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    s = cyc;
    earliest = s + STARTUP_CYC + RST_CYC + 2;
    checks++; if (busy !== 1'b1 || done !== 1'b0)
      begin errors++; $display("FAIL start_state cyc=%0d busy=%b done=%b expected busy=1 done=0", cyc, busy, done); end
    checks++; if (frame_cnt !== 16'd0)
      begin errors++; $display("FAIL start_frame_cnt got=%0d expected=0", frame_cnt); end
    checks++; if (rom_addr !== '0)
      begin errors++; $display("FAIL start_rom_addr got=%0d expected=0", rom_addr); end
    for (int k = 0; k < 600 && !finished; k++) begin
      case (mode)
        1: begin
          if (!bp_used && writes == 3 && cyc + 1 >= earliest) begin hold = 10; bp_used = 1; end
          fifo_full = (hold > 0);
          if (hold > 0) hold--;
        end
        2: begin
          if (writes < FRAME_LEN && cyc + 1 >= earliest) begin
            fifo_usedw = (wm_cnt < 3) ? USEDW_W'(6) : USEDW_W'(5);
            wm_cnt++;
          end else fifo_usedw = USEDW_W'($urandom_range(0, 127));
        end
        3: begin
          fifo_full = ($urandom_range(0, 3) == 0);
          fifo_usedw = USEDW_W'($urandom_range(0, 9));
          start = (writes < FRAME_LEN) && ($urandom_range(0, 7) == 0);
        end
        default: begin fifo_full = 1'b0; fifo_usedw = '0; end
      endcase
      stall_in = fifo_full || (int'(fifo_usedw) >= HIGH_WM);
      step();
      start = 1'b0;
      exp_wr = (LOOP || writes < FRAME_LEN) && cyc >= earliest && !stall_in;
      checks++; if (fifo_wrreq !== exp_wr)
        begin errors++; $display("FAIL wrreq cyc=%0d got=%b expected=%b", cyc, fifo_wrreq, exp_wr); end
      if (exp_wr) begin
        exp_data = rom_val(wr_idx);
        checks++; if (fifo_data !== exp_data)
          begin errors++; $display("FAIL fifo_data cyc=%0d got=%0d expected=%0d", cyc, fifo_data, exp_data); end
        checks++; if (rom_addr !== ADDR_W'(wr_idx))
          begin errors++; $display("FAIL rom_addr cyc=%0d got=%0d expected=%0d", cyc, rom_addr, wr_idx); end
        $display("write %0d: cyc=%0d addr=%0d data=%0d", writes, cyc, rom_addr, fifo_data);
        writes++; wr_idx++; wm_cnt = 0;
        earliest = cyc + PERIOD;
        if (wr_idx == FRAME_LEN) begin wr_idx = 0; done_edge = cyc + WR_GAP; end
      end
      if (cyc == done_edge) n_frames++;
      if (done === 1'b1) n_pulses++;
      exp_done = LOOP ? (cyc == done_edge) : (done_edge >= 0 && cyc >= done_edge);
      exp_busy = LOOP || !(done_edge >= 0 && cyc >= done_edge);
      exp_rp = (cyc >= s + STARTUP_CYC) && (cyc < s + STARTUP_CYC + RST_CYC);
      checks++; if (rst_proc !== exp_rp)
        begin errors++; $display("FAIL rst_proc cyc=%0d got=%b expected=%b", cyc, rst_proc, exp_rp); end
      checks++; if (busy !== exp_busy)
        begin errors++; $display("FAIL busy cyc=%0d got=%b expected=%b", cyc, busy, exp_busy); end
      checks++; if (done !== exp_done)
        begin errors++; $display("FAIL done cyc=%0d got=%b expected=%b", cyc, done, exp_done); end
      checks++; if (frame_cnt !== 16'(n_frames))
        begin errors++; $display("FAIL frame_cnt cyc=%0d got=%0d expected=%0d", cyc, frame_cnt, n_frames); end
      if (stop_after > 0 && writes == stop_after) finished = 1;
      if (!LOOP && done_edge >= 0 && cyc >= done_edge + 3) finished = 1;
    end
    checks++; if (!finished)
      begin errors++; $display("FAIL frame_timeout writes=%0d expected_end_reached=1 got=0", writes); end
    if (stop_after == 0) begin
      checks++; if (writes != FRAME_LEN)
        begin errors++; $display("FAIL write_count got=%0d expected=%0d", writes, FRAME_LEN); end
    end
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    int f, p;
    rst_geral = 1'b1; start = 1'b0; stop = 1'b0; fifo_full = 1'b0; fifo_usedw = '0;
    step(); step();
    checks++; if ({rom_addr, fifo_data, fifo_wrreq, rst_proc, busy, done, frame_cnt} !== '0)
      begin errors++; $display("FAIL reset_outputs got addr=%0d data=%0d wr=%b rp=%b busy=%b done=%b fc=%0d expected all 0",
                               rom_addr, fifo_data, fifo_wrreq, rst_proc, busy, done, frame_cnt); end
    rst_geral = 1'b0;
    step();
    run_frame(0, 3, f, p);
    #2 rst_geral = 1'b1;
    #1;
    checks++; if ({rom_addr, fifo_data, fifo_wrreq, rst_proc, busy, done, frame_cnt} !== '0)
      begin errors++; $display("FAIL async_reset got addr=%0d data=%0d wr=%b busy=%b expected all 0",
                               rom_addr, fifo_data, fifo_wrreq, busy); end
    step();
    rst_geral = 1'b0;
    step();
    run_frame(0, LOOP ? FRAME_LEN : 0, f, p);
`ifdef FEED_LOOP_EN
    do_stop();
`endif
  endtask

  task automatic test_abort();
    int f, p;
    run_frame(0, LOOP ? 10 : 2, f, p);
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    checks++; if (fifo_wrreq !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rst_proc !== 1'b0)
      begin errors++; $display("FAIL abort_state wr=%b busy=%b done=%b rp=%b expected all 0", fifo_wrreq, busy, done, rst_proc); end
    checks++; if (frame_cnt !== 16'(f))
      begin errors++; $display("FAIL abort_frame_cnt got=%0d expected=%0d", frame_cnt, f); end
    for (int i = 0; i < 20; i++) begin
      fifo_full = ($urandom_range(0, 1) == 1);
      fifo_usedw = USEDW_W'($urandom_range(0, 9));
      step();
      checks++; if (fifo_wrreq !== 1'b0 || busy !== 1'b0)
        begin errors++; $display("FAIL abort_idle cyc=%0d wr=%b busy=%b expected 0 0", cyc, fifo_wrreq, busy); end
    end
    run_frame(0, LOOP ? FRAME_LEN : 0, f, p);
`ifdef FEED_LOOP_EN
    do_stop();
`endif
  endtask

`ifdef FEED_LOOP_EN
  task automatic test_loop();
    int f, p;
    run_frame(0, 20, f, p);
    checks++; if (f != 2 || frame_cnt !== 16'd2)
      begin errors++; $display("FAIL loop_frames got=%0d expected=2", frame_cnt); end
    checks++; if (p != 2)
      begin errors++; $display("FAIL loop_done_pulses got=%0d expected=2", p); end
    do_stop();
    checks++; if (busy !== 1'b0)
      begin errors++; $display("FAIL loop_stop_busy got=%b expected=0", busy); end
  endtask
`else
  task automatic test_nominal();
    int f, p;
    run_frame(0, 0, f, p);
    checks++; if (f != 1 || p == 0)
      begin errors++; $display("FAIL nominal_frames got=%0d pulses=%0d expected 1 frame with done", f, p); end
  endtask

  task automatic test_backpressure();
    int f, p;
    run_frame(1, 0, f, p);
  endtask

  task automatic test_watermark();
    int f, p;
    run_frame(2, 0, f, p);
  endtask

  task automatic test_random();
    int f, p;
    for (int i = 0; i < 3; i++) run_frame(3, 0, f, p);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifdef FEED_LOOP_EN
    test_loop();
`else
    test_nominal();
    test_backpressure();
    test_watermark();
    test_random();
`endif
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_feed_ctrl.md
Name: fifo_feed_ctrl

Overview:
- Sequencer that brings the processor out of reset and streams one frame of samples from a synchronous sample ROM into the processor input FIFO.
- Sits between the sample ROM, the input FIFO (`data`/`wrreq`/`full`/`usedw`) and the processor `rst_proc` input at top-level integration.
- Generates a timed processor reset pulse, then paced FIFO writes with back-pressure from FIFO fill level.

Parameters:
- DATA_W, 16, sample width.
- ADDR_W, 10, ROM address width.
- FRAME_LEN, 640, samples per frame (2..2^ADDR_W).
- STARTUP_CYC, 16383, cycles waited after start before processor reset pulse (>=1).
- RST_CYC, 1, width of rst_proc pulse in cycles (>=1).
- WR_GAP, 2, idle cycles after each write (>=1).
- USEDW_W, 7, FIFO usedw width.
- HIGH_WM, 60, stall writes while fifo_usedw >= HIGH_WM.

Ports:
- clk, in, 1, system clock, all logic on rising edge.
- rst_geral, in, 1, asynchronous active-high reset.
- start, in, 1, one-cycle start request; honoured only in IDLE or DONE.
- stop, in, 1, synchronous abort; returns to IDLE next edge; has priority over start.
- rom_addr, out, ADDR_W, registered ROM address.
- rom_data, in, DATA_W signed, ROM output, valid 1 cycle after rom_addr.
- fifo_full, in, 1, FIFO full flag.
- fifo_usedw, in, USEDW_W, FIFO fill level.
- fifo_data, out, DATA_W signed, registered FIFO write data.
- fifo_wrreq, out, 1, FIFO write strobe, one cycle per sample.
- rst_proc, out, 1, processor reset pulse.
- busy, out, 1, high in any state except IDLE/DONE.
- done, out, 1, frame complete.
- frame_cnt, out, 16, completed frames since start.

Behaviour:
- Reset: async on rst_geral high. State IDLE; all outputs 0; sample index 0; counters 0.
- All outputs are registered.
- States: IDLE, DELAY, PRST, ADDR, DATA, GAP, DONE.
- IDLE/DONE + start: go to DELAY; index := 0, rom_addr := 0, frame_cnt := 0, done := 0.
- DELAY: count STARTUP_CYC cycles, then PRST.
- PRST: rst_proc = 1 for exactly RST_CYC cycles, then ADDR.
- ADDR: rom_addr = index stable; 1 cycle, then DATA.
- DATA write condition: rom_data valid.
  - If fifo_full = 1 or fifo_usedw >= HIGH_WM: stay in DATA, no write, rom_addr held.
  - Otherwise: fifo_data := rom_data, fifo_wrreq := 1 on the next cycle only, go to GAP.
  - Back-pressure is sampled in the DATA cycle. A write is never issued while fifo_full is seen high.
- GAP: WR_GAP cycles with fifo_wrreq = 0 after its 1-cycle strobe; fifo_data held.
  - At GAP exit: if index == FRAME_LEN-1, go to DONE; else index++, rom_addr := index+1, go to ADDR.
- Unstalled write period: 2 + WR_GAP cycles (4 at defaults).
- DONE: done = 1 (sticky); frame_cnt := frame_cnt+1 on entry; busy = 0; waits for start.
- stop in any state: next edge goes to IDLE; fifo_wrreq, rst_proc, busy, done := 0; a pending, not-yet-issued write is dropped; frame_cnt held.
- start while busy: ignored. start and stop in the same cycle: stop wins.
- frame_cnt wraps modulo 2^16.
- Index never exceeds FRAME_LEN-1; rom_addr never exceeds FRAME_LEN-1.

Optional Feature:
- Macro: FEED_LOOP_EN.
- Defined:
  - At GAP exit with index == FRAME_LEN-1: index and rom_addr wrap to 0; frame_cnt++; done pulses high for exactly 1 cycle; go to ADDR.
  - The frame repeats until stop; DONE is never entered; busy stays 1.
  - No extra rst_proc pulse between frames.
- Undefined: single frame then DONE, as above.

Test Plan:
(Test params: FRAME_LEN=8, STARTUP_CYC=5, RST_CYC=2, WR_GAP=2, HIGH_WM=6, ROM[i]=100*i-300.)
- Reset check: assert rst_geral mid-frame (after 3 writes) -> all outputs 0 asynchronously; after release and start, the frame restarts at rom_addr 0 with fifo_data -300 first.
- Nominal frame: start pulse, fifo_full=0, usedw=0 ->
  - rst_proc high exactly 2 cycles, beginning 5 cycles after start is sampled;
  - then 8 wrreq strobes spaced 4 cycles with data -300,-200,...,400;
  - then done=1, busy=0, frame_cnt=1.
- Back-pressure: hold fifo_full=1 during the 4th DATA cycle for 10 cycles -> no wrreq during the stall; on release, data 0 written once; total writes still 8 with no duplicates.
- Watermark: fifo_usedw=6 at each DATA cycle -> no writes; drop to 5 -> write resumes next cycle.
- Abort/priority: stop asserted in GAP after the 2nd write, with start in the same cycle -> IDLE next edge, wrreq=0, busy=0, no further writes; a later start restarts at address 0.
- FEED_LOOP_EN defined: run 20 writes -> rom_addr sequence 0..7,0..7,0..3; done pulses 1 cycle twice; frame_cnt=2; busy stays 1; rst_proc pulses only once.
